// File: rtl/q_episode_ctrl_if.sv
// Transaction and status bundle between the Q-learning episode controller and its host/pipeline.
interface q_episode_ctrl_if;
    logic        start;
    logic [5:0]  start_state;
    logic        ext_act_en;
    logic [1:0]  ext_act;
    logic        pipe_ready;
    logic        issue_valid;
    logic [5:0]  issue_s;
    logic [1:0]  issue_a;
    logic [5:0]  issue_nexts;
    logic [7:0]  issue_addr;
    logic        hazard_stall;
    logic        episode_done;
    logic        done;
    logic        busy;
    logic [7:0]  episode_cnt;
    logic [7:0]  step_cnt;
    logic [15:0] stall_cnt;

    modport master (
        input  start, start_state, ext_act_en, ext_act, pipe_ready,
        output issue_valid, issue_s, issue_a, issue_nexts, issue_addr,
        output hazard_stall, episode_done, done, busy,
        output episode_cnt, step_cnt, stall_cnt
    );

    modport slave (
        output start, start_state, ext_act_en, ext_act, pipe_ready,
        input  issue_valid, issue_s, issue_a, issue_nexts, issue_addr,
        input  hazard_stall, episode_done, done, busy,
        input  episode_cnt, step_cnt, stall_cnt
    );
endinterface

// File: rtl/q_episode_ctrl.sv
// Episode sequencer for the Q-learning update pipeline: issues one (s, a, s') per cycle and
// holds back candidates that would read a Q or Qmax entry still awaiting write-back.
module q_episode_ctrl #(
    parameter logic [5:0]  GOAL         = 6'b111111,
    parameter int unsigned MAX_STEPS    = 255,
    parameter int unsigned NUM_EPISODES = 16,
    parameter int unsigned PIPE_DEPTH   = 4,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    q_episode_ctrl_if.master bus
);
    typedef enum logic [1:0] { IDLE, RUN, DRAIN } state_e;

    localparam logic [7:0] NUM_M1 = 8'(NUM_EPISODES - 1);
    localparam logic [7:0] MAX_S  = 8'(MAX_STEPS);

    state_e state_q, state_d;

    logic [5:0]                 cur_q, cur_d, home_q, home_d;
    logic [15:0]                lfsr_q, lfsr_d;
    logic [PIPE_DEPTH-1:0]      sbv_q, sbv_d;
    logic [PIPE_DEPTH-1:0][7:0] sbe_q, sbe_d;
    logic                       valid_q, valid_d, hazard_q, hazard_d;
    logic                       epd_q, epd_d, done_q, done_d, busy_q;
    logic [5:0]                 s_q, s_d, nexts_q, nexts_d;
    logic [1:0]                 a_q, a_d;
    logic [7:0]                 epcnt_q, epcnt_d, step_q, step_d;
    logic [15:0]                stall_q, stall_d;

    logic [1:0] cand_a;
    logic [5:0] cand_n;
    logic       hazard_hit, drain_empty, ep_end;

    always_comb begin
        cand_a = bus.ext_act_en ? bus.ext_act : lfsr_q[1:0];
        case (cand_a)
            2'b00:   cand_n = (cur_q[5:3] == 3'd0) ? cur_q : cur_q - 6'd8;
            2'b01:   cand_n = (cur_q[2:0] == 3'd0) ? cur_q : cur_q - 6'd1;
            2'b10:   cand_n = (cur_q[5:3] == 3'd7) ? cur_q : cur_q + 6'd8;
            default: cand_n = (cur_q[2:0] == 3'd7) ? cur_q : cur_q + 6'd1;
        endcase
        hazard_hit = 1'b0;
        for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            if (sbv_q[i] && ((sbe_q[i] == {cur_q, cand_a}) || (sbe_q[i][7:2] == cand_n))) begin
                hazard_hit = 1'b1;
            end
        end
        // Empty after this edge: the last slot drops out and slot 0 takes a bubble.
        drain_empty = 1'b1;
        for (int unsigned i = 0; i + 1 < PIPE_DEPTH; i++) begin
            if (sbv_q[i]) drain_empty = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.pipe_ready) begin
            case (state_q)
                IDLE:    if (bus.start) state_d = RUN;
                RUN:     if (ep_end && (epcnt_q == NUM_M1)) state_d = DRAIN;
                DRAIN:   if (drain_empty) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ep_end   = 1'b0;
        valid_d  = 1'b0;
        hazard_d = 1'b0;
        epd_d    = 1'b0;
        done_d   = 1'b0;
        s_d      = s_q;
        a_d      = a_q;
        nexts_d  = nexts_q;
        cur_d    = cur_q;
        home_d   = home_q;
        lfsr_d   = lfsr_q;
        epcnt_d  = epcnt_q;
        step_d   = step_q;
        stall_d  = stall_q;
        sbv_d    = sbv_q;
        sbe_d    = sbe_q;
        if (bus.pipe_ready) begin
            sbv_d[0] = 1'b0;
            sbe_d[0] = '0;
            for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
                sbv_d[i] = sbv_q[i-1];
                sbe_d[i] = sbe_q[i-1];
            end
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        home_d  = bus.start_state;
                        cur_d   = bus.start_state;
                        epcnt_d = '0;
                        step_d  = '0;
                        stall_d = '0;
                    end
                end
                RUN: begin
                    if (cur_q == GOAL) begin
                        ep_end = 1'b1;
                    end else if (hazard_hit) begin
                        hazard_d = 1'b1;
                        if (stall_q != '1) stall_d = stall_q + 16'd1;
                    end else begin
                        valid_d  = 1'b1;
                        s_d      = cur_q;
                        a_d      = cand_a;
                        nexts_d  = cand_n;
                        cur_d    = cand_n;
                        step_d   = step_q + 8'd1;
                        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                        sbv_d[0] = 1'b1;
                        sbe_d[0] = {cur_q, cand_a};
                        ep_end   = (cand_n == GOAL) || ((step_q + 8'd1) == MAX_S);
                    end
                    if (ep_end) begin
                        epd_d   = 1'b1;
                        epcnt_d = epcnt_q + 8'd1;
                        step_d  = '0;
                        cur_d   = home_q;
                    end
                end
                DRAIN: begin
                    if (drain_empty) done_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_q    <= '0;
            home_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            sbv_q    <= '0;
            sbe_q    <= '0;
            valid_q  <= 1'b0;
            hazard_q <= 1'b0;
            epd_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            s_q      <= '0;
            a_q      <= '0;
            nexts_q  <= '0;
            epcnt_q  <= '0;
            step_q   <= '0;
            stall_q  <= '0;
        end else begin
            cur_q    <= cur_d;
            home_q   <= home_d;
            lfsr_q   <= lfsr_d;
            sbv_q    <= sbv_d;
            sbe_q    <= sbe_d;
            valid_q  <= valid_d;
            hazard_q <= hazard_d;
            epd_q    <= epd_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
            s_q      <= s_d;
            a_q      <= a_d;
            nexts_q  <= nexts_d;
            epcnt_q  <= epcnt_d;
            step_q   <= step_d;
            stall_q  <= stall_d;
        end
    end

    assign bus.issue_valid  = valid_q;
    assign bus.issue_s      = s_q;
    assign bus.issue_a      = a_q;
    assign bus.issue_nexts  = nexts_q;
    assign bus.issue_addr   = {s_q, a_q};
    assign bus.hazard_stall = hazard_q;
    assign bus.episode_done = epd_q;
    assign bus.done         = done_q;
    assign bus.busy         = busy_q;
    assign bus.episode_cnt  = epcnt_q;
    assign bus.step_cnt     = step_q;
    assign bus.stall_cnt    = stall_q;
endmodule
